vram_cursor_controller: RTL and testbench

//  Terminal sequencer between the keyboard byte stream and the vram write port.

---
 rtl/vram_cursor_controller_pkg.sv | 27 ++
 rtl/vram_cursor_controller_if.sv | 26 ++
 rtl/vram_cursor_controller_row_fill.sv | 73 +++++++
 rtl/vram_cursor_controller.sv | 174 +++++++++++++++++
 tb/tb_vram_cursor_controller.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vram_cursor_controller_pkg.sv
// Shared constants, state encoding and byte classification for the terminal
// cursor controller and its row-fill engine.
package vram_cursor_controller_pkg;

  localparam logic LOW = 1'b0;
  localparam logic YES = 1'b1;

  localparam int COL_W = 7;

  localparam logic [7:0] CHAR_BS    = 8'h08;
  localparam logic [7:0] CHAR_LF    = 8'h0A;
  localparam logic [7:0] CHAR_FF    = 8'h0C;
  localparam logic [7:0] CHAR_CR    = 8'h0D;
  localparam logic [7:0] CHAR_SPACE = 8'h20;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_WRITE = 2'd2,
    ST_ERASE = 2'd3
  } state_e;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= 8'h20) && (b <= 8'h7E);
  endfunction

endpackage

// File: rtl/vram_cursor_controller_if.sv
// Keyboard byte stream and vram write port bundled for the cursor controller.
interface vram_cursor_controller_if #(
  parameter int ROW_BITS = 5
) ();
  import vram_cursor_controller_pkg::*;

  logic                rx_valid;
  logic                rx_ready;
  logic [7:0]          rx_data;
  logic                vram_write_valid;
  logic                vram_write_ready;
  logic [ROW_BITS-1:0] vram_write_row;
  logic [COL_W-1:0]    vram_write_col;
  logic [7:0]          vram_write_char;

  modport master (
    input  rx_valid, rx_data, vram_write_ready,
    output rx_ready, vram_write_valid, vram_write_row, vram_write_col, vram_write_char
  );

  modport slave (
    output rx_valid, rx_data, vram_write_ready,
    input  rx_ready, vram_write_valid, vram_write_row, vram_write_col, vram_write_char
  );

endinterface

// File: rtl/vram_cursor_controller_row_fill.sv
// Row-major column/row fill counter emitting one space-write beat per ready
// cycle over row_count consecutive physical rows starting at first_row.
module vram_cursor_controller_row_fill
  import vram_cursor_controller_pkg::*;
#(
  parameter int COLS     = 100,
  parameter int ROW_BITS = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ROW_BITS-1:0] first_row,
  input  logic [ROW_BITS:0]   row_count,
  input  logic                ready,
  output logic                valid,
  output logic [ROW_BITS-1:0] row,
  output logic [COL_W-1:0]    col,
  output logic                last
);

  localparam logic [COL_W-1:0]  LAST_COL = COL_W'(COLS - 1);
  localparam logic [ROW_BITS:0] ONE_ROW  = (ROW_BITS + 1)'(1);

  logic                busy_q, busy_d;
  logic [ROW_BITS-1:0] row_q, row_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [ROW_BITS:0]   left_q, left_d;
  logic                beat, row_end;

  always_comb begin
    beat    = busy_q && ready;
    row_end = (col_q == LAST_COL);
    last    = beat && row_end && (left_q == ONE_ROW);
    busy_d  = busy_q;
    row_d   = row_q;
    col_d   = col_q;
    left_d  = left_q;
    if (start && !busy_q) begin
      busy_d = YES;
      row_d  = first_row;
      col_d  = '0;
      left_d = row_count;
    end else if (beat) begin
      if (row_end) begin
        col_d  = '0;
        row_d  = row_q + ROW_BITS'(1);
        left_d = left_q - ONE_ROW;
        if (left_q == ONE_ROW) busy_d = LOW;
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= LOW;
      row_q  <= '0;
      col_q  <= '0;
      left_q <= '0;
    end else begin
      busy_q <= busy_d;
      row_q  <= row_d;
      col_q  <= col_d;
      left_q <= left_d;
    end
  end

  assign valid = busy_q;
  assign row   = row_q;
  assign col   = col_q;

endmodule

// File: rtl/vram_cursor_controller.sv
// Terminal sequencer: interprets keyboard bytes, tracks the cursor, scrolls by
// moving top_row and owns the single vram write port.
module vram_cursor_controller
  import vram_cursor_controller_pkg::*;
#(
  parameter int COLS         = 100,
  parameter int VISIBLE_ROWS = 30,
  parameter int ROW_BITS     = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  vram_cursor_controller_if.master bus,
  output logic [ROW_BITS-1:0]   top_row,
  output logic [ROW_BITS-1:0]   cursor_row,
  output logic [COL_W-1:0]      cursor_col
);

  localparam logic [COL_W-1:0]    LAST_COL = COL_W'(COLS - 1);
  localparam logic [ROW_BITS-1:0] LAST_VIS = ROW_BITS'(VISIBLE_ROWS - 1);
  localparam logic [ROW_BITS:0]   ALL_ROWS = (ROW_BITS + 1)'(2 ** ROW_BITS);
  localparam logic [ROW_BITS:0]   ONE_ROW  = (ROW_BITS + 1)'(1);

  state_e              state_q, state_d;
  logic [ROW_BITS-1:0] top_q, top_d, crow_q, crow_d;
  logic [COL_W-1:0]    ccol_q, ccol_d;
  logic                wr_valid_q, wr_valid_d, wr_bs_q, wr_bs_d;
  logic [ROW_BITS-1:0] wr_row_q, wr_row_d;
  logic [COL_W-1:0]    wr_col_q, wr_col_d;
  logic [7:0]          wr_char_q, wr_char_d;

  logic                fill_mode, fill_start, fill_valid, fill_last, do_nl;
  logic [ROW_BITS-1:0] fill_row, phys;
  logic [COL_W-1:0]    fill_col;

  assign phys       = top_q + crow_q;
  assign fill_mode  = (state_q == ST_CLEAR) || (state_q == ST_ERASE);
  assign fill_start = fill_mode && !fill_valid;

  // ERASE blanks only the new bottom row; CLEAR sweeps the whole circular buffer.
  vram_cursor_controller_row_fill #(.COLS(COLS), .ROW_BITS(ROW_BITS)) u_fill (
    .clk       (clk),
    .reset     (reset),
    .start     (fill_start),
    .first_row ((state_q == ST_ERASE) ? (top_q + LAST_VIS) : '0),
    .row_count ((state_q == ST_ERASE) ? ONE_ROW : ALL_ROWS),
    .ready     (bus.vram_write_ready),
    .valid     (fill_valid),
    .row       (fill_row),
    .col       (fill_col),
    .last      (fill_last)
  );

  always_comb begin
    state_d    = state_q;
    top_d      = top_q;
    crow_d     = crow_q;
    ccol_d     = ccol_q;
    wr_valid_d = wr_valid_q;
    wr_bs_d    = wr_bs_q;
    wr_row_d   = wr_row_q;
    wr_col_d   = wr_col_q;
    wr_char_d  = wr_char_q;
    do_nl      = LOW;
    case (state_q)
      ST_CLEAR: begin
        if (fill_last) begin
          crow_d  = '0;
          ccol_d  = '0;
          state_d = ST_IDLE;
        end
      end
      ST_ERASE: begin
        if (fill_last) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (bus.rx_valid) begin
          if (is_printable(bus.rx_data)) begin
            wr_valid_d = YES;
            wr_bs_d    = LOW;
            wr_row_d   = phys;
            wr_col_d   = ccol_q;
            wr_char_d  = bus.rx_data;
            state_d    = ST_WRITE;
          end else if (bus.rx_data == CHAR_CR) begin
            ccol_d = '0;
          end else if (bus.rx_data == CHAR_LF) begin
            do_nl = YES;
          end else if (bus.rx_data == CHAR_BS) begin
            // Cursor steps back now; completion of the blanking write leaves it alone.
            if (ccol_q != '0) begin
              ccol_d     = ccol_q - COL_W'(1);
              wr_valid_d = YES;
              wr_bs_d    = YES;
              wr_row_d   = phys;
              wr_col_d   = ccol_q - COL_W'(1);
              wr_char_d  = CHAR_SPACE;
              state_d    = ST_WRITE;
            end
          end else if (bus.rx_data == CHAR_FF) begin
            top_d   = '0;
            state_d = ST_CLEAR;
          end
        end
      end
      ST_WRITE: begin
        if (wr_valid_q && bus.vram_write_ready) begin
          wr_valid_d = LOW;
          state_d    = ST_IDLE;
          if (!wr_bs_q) begin
            if (ccol_q == LAST_COL) begin
              ccol_d = '0;
              do_nl  = YES;
            end else begin
              ccol_d = ccol_q + COL_W'(1);
            end
          end
        end
      end
      default: state_d = ST_CLEAR;
    endcase
    if (do_nl) begin
      if (crow_q < LAST_VIS) begin
        crow_d = crow_q + ROW_BITS'(1);
      end else begin
        top_d   = top_q + ROW_BITS'(1);
        state_d = ST_ERASE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_CLEAR;
      top_q      <= '0;
      crow_q     <= '0;
      ccol_q     <= '0;
      wr_valid_q <= LOW;
      wr_bs_q    <= LOW;
      wr_row_q   <= '0;
      wr_col_q   <= '0;
      wr_char_q  <= CHAR_SPACE;
    end else begin
      state_q    <= state_d;
      top_q      <= top_d;
      crow_q     <= crow_d;
      ccol_q     <= ccol_d;
      wr_valid_q <= wr_valid_d;
      wr_bs_q    <= wr_bs_d;
      wr_row_q   <= wr_row_d;
      wr_col_q   <= wr_col_d;
      wr_char_q  <= wr_char_d;
    end
  end

  always_comb begin
    if (fill_mode) begin
      bus.vram_write_valid = fill_valid;
      bus.vram_write_row   = fill_row;
      bus.vram_write_col   = fill_col;
      bus.vram_write_char  = CHAR_SPACE;
    end else begin
      bus.vram_write_valid = wr_valid_q;
      bus.vram_write_row   = wr_row_q;
      bus.vram_write_col   = wr_col_q;
      bus.vram_write_char  = wr_char_q;
    end
  end

  assign bus.rx_ready = (state_q == ST_IDLE);
  assign top_row      = top_q;
  assign cursor_row   = crow_q;
  assign cursor_col   = ccol_q;

endmodule

// File: tb/tb_vram_cursor_controller.sv
// Bench for vram_cursor_controller: scoreboarded vram writes, a vector table of
// byte effects, and directed sequences for clear, scroll, wrap and reset.
module tb_vram_cursor_controller;
  import vram_cursor_controller_pkg::*;

  localparam int COLS  = 100;
  localparam int VR    = 30;
  localparam int RB    = 5;
  localparam int NROWS = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vram_cursor_controller_if #(.ROW_BITS(RB)) bus ();
  logic [RB-1:0] top_row, cursor_row;
  logic [6:0]    cursor_col;

  vram_cursor_controller #(.COLS(COLS), .VISIBLE_ROWS(VR), .ROW_BITS(RB)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .top_row    (top_row),
    .cursor_row (cursor_row),
    .cursor_col (cursor_col)
  );

  logic rdy = 1'b1;
  logic rnd_mode = 1'b0;
  logic rnd_bit = 1'b1;
  assign bus.vram_write_ready = rnd_mode ? rnd_bit : rdy;
  always @(posedge clk) begin
    #1 rnd_bit = ($urandom_range(0, 3) != 0);
  end

  typedef struct packed {
    logic [RB-1:0] row;
    logic [6:0]    col;
    logic [7:0]    ch;
  } wr_t;

  typedef struct {
    logic [7:0] d;
    bit         wr;
    int         wrow;
    int         wcol;
    logic [7:0] wch;
    int         crow;
    int         ccol;
    int         top;
  } vec_t;

  wr_t  sb[$];
  vec_t vt[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_beat_cyc = -1;
  int beats = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    wr_t a, e;
    if (bus.vram_write_valid && bus.vram_write_ready) begin
      beats++;
      last_beat_cyc = cyc;
      total++;
      a = '{bus.vram_write_row, bus.vram_write_col, bus.vram_write_char};
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: got row=%0d col=%0d char=%02h, required no write",
                 a.row, a.col, a.ch);
      end else begin
        e = sb.pop_front();
        if (a !== e) begin
          bad++;
          $display("FAIL write: got row=%0d col=%0d char=%02h, required row=%0d col=%0d char=%02h",
                   a.row, a.col, a.ch, e.row, e.col, e.ch);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic push_row(input int r);
    for (int c = 0; c < COLS; c++) sb.push_back('{RB'(r), 7'(c), CHAR_SPACE});
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (!(bus.rx_ready && sb.size() == 0) && n < budget) begin
      step();
      n++;
    end
    total++;
    if (!(bus.rx_ready && sb.size() == 0)) begin
      bad++;
      $display("FAIL %s_timeout: got rx_ready=%0b pending=%0d, required idle within %0d cycles",
               name, bus.rx_ready, sb.size(), budget);
    end
  endtask

  task automatic send_byte(input logic [7:0] d);
    int n = 0;
    while (!bus.rx_ready && n < 20000) begin
      step();
      n++;
    end
    if (!bus.rx_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got rx_ready=0, required 1 for byte %02h", d);
    end
    bus.rx_valid = 1'b1;
    bus.rx_data  = d;
    step();
    bus.rx_valid = 1'b0;
  endtask

  task automatic wait_ready_after_reset(input string name);
    int n = 0;
    while (!bus.rx_ready && n < 5000) begin
      step();
      n++;
    end
    chk({name, "_rx_ready"}, int'(bus.rx_ready), 1);
  endtask

  initial begin
    int b0;
    int top_e;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;

    // Reset state and initial clear
    step();
    step();
    chk("rst_valid", int'(bus.vram_write_valid), 0);
    chk("rst_row", int'(bus.vram_write_row), 0);
    chk("rst_col", int'(bus.vram_write_col), 0);
    chk("rst_char", int'(bus.vram_write_char), 32'h20);
    chk("rst_top", int'(top_row), 0);
    chk("rst_cursor", {cursor_row, cursor_col}, 0);
    chk("rst_rx_ready", int'(bus.rx_ready), 0);
    for (int r = 0; r < NROWS; r++) push_row(r);
    reset = 1'b0;
    wait_ready_after_reset("clear0");
    chk("clear0_ready_latency", cyc - last_beat_cyc, 1);
    chk("clear0_beats", beats, NROWS * COLS);
    chk("clear0_pending", sb.size(), 0);
    chk("clear0_valid_low", int'(bus.vram_write_valid), 0);
    chk("clear0_cursor", {cursor_row, cursor_col}, 0);

    // 'A' with ready held low: beat must stay stable
    rdy = 1'b0;
    sb.push_back('{RB'(0), 7'd0, 8'h41});
    send_byte(8'h41);
    for (int i = 0; i < 5; i++) begin
      chk("A_hold", {bus.vram_write_valid, bus.vram_write_row, bus.vram_write_col,
                     bus.vram_write_char}, {1'b1, 5'd0, 7'd0, 8'h41});
      chk("A_rx_ready_low", int'(bus.rx_ready), 0);
      step();
    end
    rdy = 1'b1;
    wait_idle("A", 20);
    chk("A_ccol", int'(cursor_col), 1);

    // Byte effect table, starting at cursor (0,1), top 0
    vt.push_back('{8'h0D, 0, 0, 0, 8'h00, 0, 0, 0});
    vt.push_back('{8'h42, 1, 0, 0, 8'h42, 0, 1, 0});
    vt.push_back('{8'h07, 0, 0, 0, 8'h00, 0, 1, 0});
    vt.push_back('{8'h7E, 1, 0, 1, 8'h7E, 0, 2, 0});
    vt.push_back('{8'h7F, 0, 0, 0, 8'h00, 0, 2, 0});
    vt.push_back('{8'h0A, 0, 0, 0, 8'h00, 1, 2, 0});
    vt.push_back('{8'h08, 1, 1, 1, 8'h20, 1, 1, 0});
    vt.push_back('{8'h08, 1, 1, 0, 8'h20, 1, 0, 0});
    vt.push_back('{8'h08, 0, 0, 0, 8'h00, 1, 0, 0});
    vt.push_back('{8'h1F, 0, 0, 0, 8'h00, 1, 0, 0});
    vt.push_back('{8'h31, 1, 1, 0, 8'h31, 1, 1, 0});
    vt.push_back('{8'h32, 1, 1, 1, 8'h32, 1, 2, 0});
    vt.push_back('{8'h33, 1, 1, 2, 8'h33, 1, 3, 0});
    vt.push_back('{8'h34, 1, 1, 3, 8'h34, 1, 4, 0});
    vt.push_back('{8'h35, 1, 1, 4, 8'h35, 1, 5, 0});
    vt.push_back('{8'h08, 1, 1, 4, 8'h20, 1, 4, 0});
    vt.push_back('{8'h0D, 0, 0, 0, 8'h00, 1, 0, 0});
    vt.push_back('{8'h0A, 0, 0, 0, 8'h00, 2, 0, 0});
    vt.push_back('{8'h80, 0, 0, 0, 8'h00, 2, 0, 0});
    vt.push_back('{8'h20, 1, 2, 0, 8'h20, 2, 1, 0});
    foreach (vt[i]) begin
      if (vt[i].wr) sb.push_back('{RB'(vt[i].wrow), 7'(vt[i].wcol), vt[i].wch});
      send_byte(vt[i].d);
      wait_idle("vec", 50);
      chk($sformatf("vec%0d_crow", i), int'(cursor_row), vt[i].crow);
      chk($sformatf("vec%0d_ccol", i), int'(cursor_col), vt[i].ccol);
      chk($sformatf("vec%0d_top", i), int'(top_row), vt[i].top);
    end

    // BS at column 0: nothing written, still accepting
    send_byte(CHAR_CR);
    b0 = beats;
    send_byte(CHAR_BS);
    chk("bs0_rx_ready", int'(bus.rx_ready), 1);
    step();
    chk("bs0_no_write", beats - b0, 0);
    chk("bs0_ccol", int'(cursor_col), 0);

    // 100 printables on row 2 wrap to the next row without scrolling
    for (int c = 0; c < COLS; c++) begin
      sb.push_back('{RB'(2), 7'(c), 8'h78});
      send_byte(8'h78);
      wait_idle("row_fill", 50);
    end
    chk("wrap_crow", int'(cursor_row), 3);
    chk("wrap_ccol", int'(cursor_col), 0);
    chk("wrap_top", int'(top_row), 0);

    // Walk down to the bottom row, then scroll
    for (int i = 0; i < 26; i++) begin
      send_byte(CHAR_LF);
      wait_idle("lf_walk", 20);
    end
    chk("bottom_crow", int'(cursor_row), 29);
    push_row(30);
    send_byte(CHAR_LF);
    wait_idle("scroll1", 500);
    chk("scroll1_top", int'(top_row), 1);
    chk("scroll1_crow", int'(cursor_row), 29);

    top_e = 1;
    for (int k = 0; k < 30; k++) begin
      push_row((top_e + 1 + VR - 1) % NROWS);
      send_byte(CHAR_LF);
      wait_idle("scroll_n", 500);
      top_e++;
    end
    chk("scroll31_top", int'(top_row), 31);
    chk("scroll31_crow", int'(cursor_row), 29);

    // Printable on the bottom row lands on physical row (31+29) mod 32 = 28
    sb.push_back('{RB'(28), 7'(cursor_col), 8'h5A});
    send_byte(8'h5A);
    wait_idle("phys_wrap", 50);

    push_row(29);
    send_byte(CHAR_LF);
    wait_idle("scroll_wrap", 500);
    chk("scroll_wrap_top", int'(top_row), 0);
    chk("scroll_wrap_crow", int'(cursor_row), 29);
    push_row(30);
    send_byte(CHAR_LF);
    wait_idle("scroll_again", 500);
    chk("scroll_again_top", int'(top_row), 1);

    // Form feed mid-screen with random back-pressure
    rnd_mode = 1'b1;
    for (int r = 0; r < NROWS; r++) push_row(r);
    send_byte(CHAR_FF);
    chk("ff_rx_ready_low", int'(bus.rx_ready), 0);
    wait_idle("ff", 30000);
    rnd_mode = 1'b0;
    chk("ff_top", int'(top_row), 0);
    chk("ff_cursor", {cursor_row, cursor_col}, 0);

    // Reset while a write is stalled
    rdy = 1'b0;
    send_byte(8'h51);
    chk("rstw_valid_before", int'(bus.vram_write_valid), 1);
    reset = 1'b1;
    step();
    chk("rstw_valid_after", int'(bus.vram_write_valid), 0);
    chk("rstw_rx_ready", int'(bus.rx_ready), 0);
    for (int r = 0; r < NROWS; r++) push_row(r);
    rdy = 1'b1;
    step();
    reset = 1'b0;
    wait_ready_after_reset("rstw_clear");
    chk("rstw_pending", sb.size(), 0);
    chk("rstw_cursor", {cursor_row, cursor_col}, 0);
    chk("rstw_top", int'(top_row), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got no completion, required finish before 3000000 ns");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
